// File: rtl/volume_scaler.sv
// volume_scaler: applies a volume-table gain to a signed sample stream through
// a 2-stage valid/ready pipeline, with an optional zipper-free gain ramp.
//
// Optional feature macro: VOLUME_SCALER_RAMP_EN
//   defined   -> gain steps one LSB toward target every RAMP_DIV cycles,
//                ramp_busy reports gain != target
//   undefined -> gain loads the target on the next edge, ramp_busy tied 0
//
// Ports:
//   clock      sole clock, rising edge
//   reset      asynchronous active-low reset
//   vol        volume level 0..5 (6,7 treated as 5)
//   in_valid   input sample valid
//   in_data    input sample, signed DATA_W
//   in_ready   block accepts in_data this cycle (combinational)
//   out_valid  output sample valid
//   out_data   scaled sample, signed DATA_W
//   out_ready  consumer accepts out_data this cycle
//   gain       applied gain, Q4 unsigned (16 = unity)
//   ramp_busy  high while gain is still moving toward target
module volume_scaler #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned RAMP_DIV = 256
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [2:0]               vol,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     out_ready,
  output logic [4:0]               gain,
  output logic                     ramp_busy
);

  localparam int unsigned GAIN_W = 5;
  localparam int unsigned P_W    = DATA_W + 6;

  if (RAMP_DIV < 2) begin : g_bad_ramp_div
    $error("volume_scaler: RAMP_DIV must be >= 2");
  end

  // Volume level to target gain
  logic [GAIN_W-1:0] target;
  always_comb begin
    target = 5'd16;
    case (vol)
      3'd0:    target = 5'd0;
      3'd1:    target = 5'd2;
      3'd2:    target = 5'd4;
      3'd3:    target = 5'd8;
      3'd4:    target = 5'd12;
      default: target = 5'd16;
    endcase
  end

`ifdef VOLUME_SCALER_RAMP_EN
  localparam int unsigned CNT_W = $clog2(RAMP_DIV);

  logic [CNT_W-1:0]  ramp_cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [GAIN_W-1:0] gain_next;

  // Step one LSB toward target on each counter wrap; direction is taken from
  // the current target so a reversal lands on the next wrap.
  always_comb begin
    gain_next = gain;
    cnt_next  = '0;
    if (gain != target) begin
      if (ramp_cnt == CNT_W'(RAMP_DIV - 1)) begin
        cnt_next  = '0;
        gain_next = (target > gain) ? gain + 5'd1 : gain - 5'd1;
      end else begin
        cnt_next = ramp_cnt + CNT_W'(1);
      end
    end
  end

  // Gain / ramp state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gain      <= 5'd2;
      ramp_cnt  <= '0;
      ramp_busy <= 1'b0;
    end else begin
      gain      <= gain_next;
      ramp_cnt  <= cnt_next;
      ramp_busy <= (gain_next != target);
    end
  end
`else
  // Gain follows target one edge later
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gain <= 5'd2;
    end else begin
      gain <= target;
    end
  end

  assign ramp_busy = 1'b0;
`endif

  // Pipeline advances when the output slot is empty or being drained
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic                  s1_valid;
  logic signed [P_W-1:0] p_r;
  logic signed [P_W-1:0] a_ext;
  logic signed [P_W-1:0] g_ext;
  logic signed [P_W-1:0] prod;
  logic signed [P_W-1:0] rnd;

  always_comb begin
    a_ext = {{(P_W - DATA_W){in_data[DATA_W-1]}}, in_data};
    g_ext = P_W'({1'b0, gain});
    prod  = a_ext * g_ext;
    // Round half up before dropping the 4 fractional gain bits
    rnd   = p_r + P_W'(8);
  end

  // Stage 1: multiply, stage 2: round and shift
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      p_r       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (in_valid) begin
        p_r <= prod;
      end
      if (s1_valid) begin
        out_data <= DATA_W'(rnd >>> 4);
      end
    end
  end

endmodule

// File: tb/tb_volume_scaler.sv
// Directed self-checking bench for volume_scaler (RAMP_DIV = 4).
module tb_volume_scaler;

  localparam int unsigned DATA_W = 16;

  logic                     clock;
  logic                     reset;
  logic [2:0]               vol;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_ready;
  logic [4:0]               gain;
  logic                     ramp_busy;

  int n_cmp = 0;
  int n_err = 0;

  volume_scaler #(.DATA_W(DATA_W), .RAMP_DIV(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .vol       (vol),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .gain      (gain),
    .ramp_busy (ramp_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the applied gain to reach a value
  task automatic wait_gain(input int exp);
    for (int i = 0; i < 200; i++) begin
      if (gain == 5'(exp)) break;
      @(negedge clock);
    end
    check("gain_reach", gain, exp);
    check("busy_after_reach", ramp_busy, 0);
  endtask

  // Three back-to-back samples, outputs expected on consecutive cycles
  task automatic stream3(input string tag,
                         input logic signed [DATA_W-1:0] d0, d1, d2,
                         input int e0, e1, e2);
    in_valid = 1'b1; in_data = d0;
    @(negedge clock);
    check({tag, "_lat"}, out_valid, 0);
    in_data = d1;
    @(negedge clock);
    check({tag, "_v0"}, out_valid, 1);
    check({tag, "_d0"}, out_data, e0);
    in_data = d2;
    @(negedge clock);
    in_valid = 1'b0;
    check({tag, "_v1"}, out_valid, 1);
    check({tag, "_d1"}, out_data, e1);
    @(negedge clock);
    check({tag, "_v2"}, out_valid, 1);
    check({tag, "_d2"}, out_data, e2);
    @(negedge clock);
    check({tag, "_drain"}, out_valid, 0);
  endtask

  initial begin
    int idx;
    int ocnt;
    logic stall;
    logic signed [DATA_W-1:0] held;

    reset = 1'b0; vol = 3'd1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    held = '0;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_gain", gain, 2);
    check("rst_busy", ramp_busy, 0);
    reset = 1'b1;
    @(negedge clock);
    check("rel_in_ready", in_ready, 1);
    check("rel_out_valid", out_valid, 0);

    // vol=1, 1000 -> 125 after two edges
    in_valid = 1'b1; in_data = 16'sd1000;
    @(negedge clock);
    in_valid = 1'b0;
    check("t1_lat", out_valid, 0);
    @(negedge clock);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 125);
    check("t1_gain", gain, 2);
    check("t1_busy", ramp_busy, 0);

    // Ramp 2 -> 16
    vol = 3'd5;
`ifdef VOLUME_SCALER_RAMP_EN
    for (int k = 1; k <= 56; k++) begin
      @(negedge clock);
      check("ramp_gain", gain, 2 + k / 4);
      check("ramp_busy", ramp_busy, (k < 56) ? 1 : 0);
    end
`else
    @(negedge clock);
    check("jump_gain", gain, 16);
    check("jump_busy", ramp_busy, 0);
`endif

    // Unity gain, extremes back-to-back
    stream3("unity", -16'sd32768, 16'sd1000, 16'sd32767, -32768, 1000, 32767);

    // Rounding at gain 2
    vol = 3'd1;
    wait_gain(2);
    stream3("round", 16'sd7, -16'sd7, -16'sd8, 1, -1, -1);

    // Gain 0
    vol = 3'd0;
    wait_gain(0);
    stream3("mute", 16'sd12345, -16'sd32768, -16'sd1, 0, 0, 0);

    // Backpressure: 5 samples, out_ready low for 3 cycles
    vol = 3'd5;
    wait_gain(16);
    idx = 0; ocnt = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clock);
      stall     = (cyc >= 3) && (cyc < 6);
      out_ready = !stall;
      in_valid  = (idx < 5);
      in_data   = 16'(11 + idx);
      #1;
      if (stall) begin
        check("bp_in_ready_low", in_ready, 0);
        check("bp_valid_held", out_valid, 1);
        if (cyc > 3) check("bp_data_held", out_data, held);
      end else begin
        check("bp_in_ready_high", in_ready, 1);
      end
      if (out_valid && out_ready) begin
        check("bp_order", out_data, 11 + ocnt);
        ocnt++;
      end
      held = out_data;
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_count", ocnt, 5);

    // Reset mid-ramp with a valid output pending
    vol = 3'd0;
    repeat (6) @(negedge clock);
    in_valid = 1'b1; in_data = 16'sd500;
    @(negedge clock);
    in_valid = 1'b1; in_data = 16'sd600;
    @(negedge clock);
    in_valid = 1'b0;
    check("mid_valid_before", out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_gain", gain, 2);
    check("async_busy", ramp_busy, 0);
    vol = 3'd5;
    @(negedge clock);
    reset = 1'b1;
`ifdef VOLUME_SCALER_RAMP_EN
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      check("restart_gain", gain, (k < 4) ? 2 : 3);
      check("restart_drop", out_valid, 0);
    end
`else
    @(negedge clock);
    check("restart_gain", gain, 16);
    check("restart_drop", out_valid, 0);
    @(negedge clock);
    check("restart_drop2", out_valid, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/volume_scaler.md
# volume_scaler

Applies the 3-bit volume level from the volume control FSM to the signed audio sample stream, directly downstream of it and upstream of the audio codec output path. The target gain comes from a fixed level table. The applied gain ramps one step at a time toward the target to avoid zipper noise. Samples pass through a 2-stage valid/ready pipeline.

## Interface
- DATA_W, 16: sample width, signed two's complement.
- RAMP_DIV, 256: clock cycles per one-LSB gain step; must be ≥2.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset; assertion clears all state immediately, release is synchronous to clock.
- vol  in  3  volume level from volume control; 0..5 valid, 6 and 7 treated as 5.
- in_valid  in  1  input sample valid.
- in_data  in  DATA_W  input sample, signed.
- in_ready  out  1  block accepts in_data this cycle.
- out_valid  out  1  output sample valid.
- out_data  out  DATA_W  scaled sample, signed.
- out_ready  in  1  consumer accepts out_data this cycle.
- gain  out  5  currently applied gain, Q4 unsigned (16 = unity).
- ramp_busy  out  1  high while gain ≠ target gain.

## Operation
- Target gain table, vol→target: 0→0, 1→2, 2→4, 3→8, 4→12, 5/6/7→16.
- Gain register:
  - Range 0..16.
  - Ramp counter counts 0..RAMP_DIV-1 while gain ≠ target.
  - On the wrap cycle, gain moves 1 toward target.
  - Counter held at 0 while gain == target.
- Target change mid-ramp: direction is re-evaluated every cycle and the counter is not cleared. Reversal takes effect at the next wrap.
- Pipeline enable: en = !out_valid || out_ready; in_ready = en.
- Stage 1:
  - Captures when en && in_valid: p = in_data × {1'b0, gain}.
  - Signed result, DATA_W+6 bits.
  - Gain is sampled at this capture.
- Stage 2:
  - out_data = (p + 8) >>> 4, arithmetic shift, truncated to DATA_W.
  - No saturation is needed, since |result| ≤ |in_data|.
  - −2^(DATA_W−1) at gain 16 is preserved exactly.
- Stage valid bits advance only when en. When en == 0, all pipeline registers hold, including out_data.
- Bubbles (in_valid = 0 while en) propagate as invalid stages.

## Timing
- Reset values:
  - out_valid = 0, out_data = 0, stage-1 valid = 0.
  - gain = 2, matching volume control reset level 1.
  - Ramp counter = 0, ramp_busy = 0.
  - in_ready = 1 in the first cycle after release.
- Latency: sample accepted at edge N appears on out_data/out_valid after edge N+1, i.e. 2 cycles, when out_ready stays high.
- Throughput: 1 sample/cycle with out_ready held high.
- Backpressure: out_valid && !out_ready holds both stages, and in_ready drops in the same cycle (combinational).
- Ramp duration: |target − gain| × RAMP_DIV cycles. ramp_busy falls on the edge where gain reaches target.
- Reset asserted mid-stream: in-flight samples are dropped, out_valid = 0 immediately, and gain returns to 2.
- vol is sampled every cycle with no synchronizer, since it shares the clock with volume control.

## Configuration
- VOLUME_SCALER_RAMP_EN defined:
  - Ramp behaviour as above.
  - ramp_busy is functional.
- VOLUME_SCALER_RAMP_EN undefined:
  - gain loads target on the next clock edge after any vol change.
  - The ramp counter is not built.
  - ramp_busy is tied 0.
  - Datapath and handshake are unchanged.

## Test plan
- Reset release, vol=1, in_data=1000 with out_ready=1 → out_data=125 two cycles later, gain=2, ramp_busy=0.
- RAMP_EN, RAMP_DIV=4, vol 1→5 → gain steps 2,3,…,16 every 4 cycles, 56 cycles total; ramp_busy high throughout, low at 16.
- gain=16, in_data=−32768, 1000, 32767 back-to-back → same values out on consecutive cycles, no bubbles.
- Rounding check:
  - gain=2, in_data=7 → 1.
  - in_data=−7 → −1.
  - in_data=−8 → −1.
  - gain=0, any input → 0.
- Backpressure: stream 5 samples, drop out_ready for 3 cycles mid-stream → in_ready low those cycles, out_data held stable, no sample lost or duplicated, order preserved.
- Reset pulsed low mid-ramp with out_valid=1 → out_valid=0 asynchronously; after release gain=2 and the counter restarts from 0.
